dma_ctrl: RTL
=============

DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have cs, input, 1, register-page chip select from CPU address decode.
REQ-004 SHALL have we, input, 1, CPU write enable.
REQ-005 SHALL have addr, input, 3, register index.
REQ-006 SHALL have din, input, 8, CPU write data.
REQ-007 SHALL have dout, output, 8, register read data, registered.
REQ-008 SHALL have irq, output, 1, level interrupt request.
REQ-009 SHALL have rdy, output, 1, CPU stall; low while the DMA owns the bus.
REQ-010 SHALL have bus_own, output, 1, high selects the DMA address, data and write enable onto the system bus.
REQ-011 SHALL have dma_ab, output, 16, DMA bus address.
REQ-012 SHALL have dma_do, output, 8, DMA write data.
REQ-013 SHALL have dma_we, output, 1, DMA write strobe.
REQ-014 SHALL have dma_di, input, 8, bus read data, valid one cycle after the address is driven.

Function
REQ-015 SHALL map registers as follows: 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H, 6 CTRL, 7 STATUS.
REQ-016 SHALL define CTRL as: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN, bit2 FILL (source address held constant), bit3 DST_HOLD (destination address held constant), bits 7:4 reserved (read 0).
REQ-017 SHALL define STATUS as: bit0 BUSY, bit1 DONE; writing any value to STATUS clears DONE.
REQ-018 SHALL return register contents on dout the cycle after a read (cs=1, we=0); SRC, DST and LEN read back their live working values.
REQ-019 SHALL ignore register writes while BUSY=1.
REQ-020 SHALL implement states IDLE, GRANT, RD, LAT, WR, FIN.
REQ-021 IDLE: on a CTRL write with START=1, clear DONE; if LEN=0, set DONE directly with no bus cycles; otherwise enter GRANT.
REQ-022 GRANT: drive rdy low for one cycle with bus_own=0 so the CPU freezes, then enter RD.
REQ-023 RD: drive bus_own=1, dma_ab=SRC and dma_we=0.
REQ-024 LAT: capture dma_di into the data latch; keep bus_own=1 and dma_we=0.
REQ-025 WR: drive dma_ab=DST, dma_do=latch and dma_we=1; decrement LEN; increment SRC unless FILL is set; increment DST unless DST_HOLD is set.
REQ-026 After WR: enter RD if the new LEN is nonzero, else enter FIN.
REQ-027 Throughput SHALL be exactly 3 cycles per byte, plus 1 GRANT cycle and 1 FIN cycle per transfer.
REQ-028 FIN: bus_own=0, rdy remains low, set DONE; the next cycle is IDLE with rdy=1.
REQ-029 SRC and DST SHALL wrap modulo 2^16 (FFFF+1 = 0000); LEN is 16-bit unsigned with a maximum of 65535.
REQ-030 BUSY SHALL be 1 in every state except IDLE; rdy SHALL equal !BUSY.
REQ-031 irq SHALL equal DONE & IRQ_EN, as a level held until DONE is cleared.
REQ-032 If a DONE-clear write and DONE-set occur in the same cycle, set SHALL win.
REQ-033 Outside RD, LAT and WR, dma_we SHALL be 0 and bus_own SHALL be 0.

Reset
REQ-034 On reset: state=IDLE, SRC=DST=LEN=0000, CTRL=00, DONE=0, dout=00, irq=0, rdy=1, bus_own=0, dma_we=0, dma_ab=0000, dma_do=00.
REQ-035 Reset asserted mid-transfer SHALL abort within one cycle to reset values; no further dma_we pulses occur and the partially copied data remains in memory.

Verification
REQ-036 Copy: SRC=0200, DST=0300, LEN=0004, START -> 4 writes to 0300..0303 with source data; rdy low for 14 cycles; DONE=1; SRC=0204, DST=0304, LEN=0000.
REQ-037 Fill: FILL=1, SRC=0010 holding 0xA5, DST=7FFE, LEN=0003 -> 7FFE, 7FFF and 8000 written with A5; SRC remains 0010.
REQ-038 Wrap: SRC=FFFF, DST=FFFE, LEN=0002 -> reads FFFF then 0000; writes FFFE then FFFF; final DST=0000.
REQ-039 Zero length: LEN=0000, START with IRQ_EN=1 -> no bus_own assertion, rdy stays 1, DONE=1 and irq=1 the next cycle; a STATUS write clears irq.
REQ-040 Abort: reset asserted during the WR of byte 2 of 8 -> all outputs at reset values the next cycle; exactly 2 dma_we pulses observed.
REQ-041 Busy lockout: a SRC_L write issued while BUSY is ignored, and the read-back shows the working value.

Source files
------------

// File: rtl/dma_ctrl.sv
// Single-channel memory-to-memory DMA engine behind an 8-register CPU page.
// Each byte costs RD, LAT and WR cycles; the CPU is held off through rdy for the whole transfer.
//
// state | meaning
// IDLE  | waiting for CTRL.START, register page writable
// GRANT | rdy low, bus still with the CPU so it can freeze
// RD    | DMA drives SRC onto the bus for a read
// LAT   | read data returns on dma_di and is latched
// WR    | DMA drives DST and latched data with dma_we high
// FIN   | bus released, rdy still low, DONE being set
module dma_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        irq,
   output logic        rdy,
   output logic        bus_own,
   output logic [15:0] dma_ab,
   output logic [7:0]  dma_do,
   output logic        dma_we,
   input  logic [7:0]  dma_di
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_RD,
      S_LAT,
      S_WR,
      S_FIN
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] src_q, src_d;
   logic [15:0] dst_q, dst_d;
   logic [15:0] len_q, len_d;
   logic        irq_en_q, irq_en_d;
   logic        fill_q, fill_d;
   logic        dst_hold_q, dst_hold_d;
   logic        done_q, done_d;
   logic [7:0]  dout_q, dout_d;
   logic        rdy_q, rdy_d;
   logic        bus_own_q, bus_own_d;
   logic [15:0] dma_ab_q, dma_ab_d;
   logic [7:0]  dma_do_q, dma_do_d;
   logic        dma_we_q, dma_we_d;
   logic        reg_wr;
   logic        busy;

   assign busy = (state_q != S_IDLE);

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      irq_en_d   = irq_en_q;
      fill_d     = fill_q;
      dst_hold_d = dst_hold_q;
      done_d     = done_q;
      dout_d     = dout_q;
      rdy_d      = rdy_q;
      bus_own_d  = bus_own_q;
      dma_ab_d   = dma_ab_q;
      dma_do_d   = dma_do_q;
      dma_we_d   = dma_we_q;

      // The register page is frozen for the whole transfer, FIN included.
      reg_wr = cs && we && (state_q == S_IDLE);
      if (reg_wr) begin
         case (addr)
            3'd0: src_d[7:0]  = din;
            3'd1: src_d[15:8] = din;
            3'd2: dst_d[7:0]  = din;
            3'd3: dst_d[15:8] = din;
            3'd4: len_d[7:0]  = din;
            3'd5: len_d[15:8] = din;
            3'd6: begin
               irq_en_d   = din[1];
               fill_d     = din[2];
               dst_hold_d = din[3];
            end
            3'd7: done_d = 1'b0;
         endcase
      end

      // DONE set is evaluated after any clear above, so set wins.
      case (state_q)
         S_IDLE: begin
            if (reg_wr && (addr == 3'd6) && din[0]) begin
               done_d = 1'b0;
               if (len_q == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_GRANT;
                  rdy_d   = 1'b0;
               end
            end
         end
         S_GRANT: begin
            state_d   = S_RD;
            bus_own_d = 1'b1;
            dma_ab_d  = src_q;
            dma_we_d  = 1'b0;
         end
         S_RD: begin
            state_d = S_LAT;
         end
         S_LAT: begin
            state_d  = S_WR;
            dma_do_d = dma_di;
            dma_ab_d = dst_q;
            dma_we_d = 1'b1;
         end
         S_WR: begin
            len_d    = len_q - 16'd1;
            dma_we_d = 1'b0;
            if (!fill_q) begin
               src_d = src_q + 16'd1;
            end
            if (!dst_hold_q) begin
               dst_d = dst_q + 16'd1;
            end
            if (len_q != 16'd1) begin
               state_d  = S_RD;
               dma_ab_d = src_d;
            end else begin
               state_d   = S_FIN;
               bus_own_d = 1'b0;
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            rdy_d   = 1'b1;
         end
         default: begin
            state_d   = S_IDLE;
            rdy_d     = 1'b1;
            bus_own_d = 1'b0;
            dma_we_d  = 1'b0;
         end
      endcase

      if (cs && !we) begin
         case (addr)
            3'd0: dout_d = src_q[7:0];
            3'd1: dout_d = src_q[15:8];
            3'd2: dout_d = dst_q[7:0];
            3'd3: dout_d = dst_q[15:8];
            3'd4: dout_d = len_q[7:0];
            3'd5: dout_d = len_q[15:8];
            3'd6: dout_d = {4'b0000, dst_hold_q, fill_q, irq_en_q, 1'b0};
            3'd7: dout_d = {6'b000000, done_q, busy};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         src_q      <= 16'h0000;
         dst_q      <= 16'h0000;
         len_q      <= 16'h0000;
         irq_en_q   <= 1'b0;
         fill_q     <= 1'b0;
         dst_hold_q <= 1'b0;
         done_q     <= 1'b0;
         dout_q     <= 8'h00;
         rdy_q      <= 1'b1;
         bus_own_q  <= 1'b0;
         dma_ab_q   <= 16'h0000;
         dma_do_q   <= 8'h00;
         dma_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         irq_en_q   <= irq_en_d;
         fill_q     <= fill_d;
         dst_hold_q <= dst_hold_d;
         done_q     <= done_d;
         dout_q     <= dout_d;
         rdy_q      <= rdy_d;
         bus_own_q  <= bus_own_d;
         dma_ab_q   <= dma_ab_d;
         dma_do_q   <= dma_do_d;
         dma_we_q   <= dma_we_d;
      end
   end

   assign dout    = dout_q;
   assign irq     = done_q & irq_en_q;
   assign rdy     = rdy_q;
   assign bus_own = bus_own_q;
   assign dma_ab  = dma_ab_q;
   assign dma_do  = dma_do_q;
   assign dma_we  = dma_we_q;

endmodule
